// File: rtl/lfsr_cipher_engine.sv
// LFSR stream-cipher engine: writes PreLen padded spaces, then the XOR-encrypted message,
// to a destination buffer through a single-port memory with combinational read.
module lfsr_cipher_engine #(
  parameter int            DW  = 8,
  parameter int            LW  = 7,
  parameter int            AW  = 8,
  parameter logic [DW-1:0] PAD = 8'h20
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [LW-1:0] Tap,
  input  logic [LW-1:0] Seed,
  input  logic [AW-1:0] SrcBase,
  input  logic [AW-1:0] DstBase,
  input  logic [AW-1:0] Len,
  input  logic [AW-1:0] PreLen,
  output logic [AW-1:0] MemAddr,
  output logic          MemWrEn,
  output logic [DW-1:0] MemWrData,
  input  logic [DW-1:0] MemRdData,
  output logic          Busy,
  output logic          Ack
);

  typedef enum logic [2:0] {IDLE, PRE, RD, WR, DONE} state_t;

  localparam logic [AW-1:0] ONE_A = {{(AW-1){1'b0}}, 1'b1};

  state_t        stateReg, stateNext;
  logic [LW-1:0] lfsrReg, tapReg;
  logic [AW-1:0] srcBaseReg, dstBaseReg, lenReg, preLenReg;
  logic [AW-1:0] iReg, jReg;
  logic [DW-1:0] rbufReg;
  logic          busyReg, ackReg;

  logic [DW-1:0] padWord;
  logic [LW-1:0] lfsrStep;
  logic          startOk, lastPre, lastMsg;

  always_comb begin
    padWord = '0;
    padWord[LW-1:0] = lfsrReg;
  end

  assign lfsrStep = {lfsrReg[LW-2:0], ^(lfsrReg & tapReg)};
  assign startOk  = Start && (stateReg == IDLE || stateReg == DONE);
  assign lastPre  = (jReg == preLenReg - ONE_A);
  assign lastMsg  = (iReg == lenReg - ONE_A);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) stateReg <= IDLE;
    else       stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE, DONE: begin
        if (Start) begin
          if (PreLen != '0)   stateNext = PRE;
          else if (Len != '0) stateNext = RD;
          else                stateNext = DONE;
        end
      end
      PRE:     if (lastPre) stateNext = (lenReg != '0) ? RD : DONE;
      RD:      stateNext = WR;
      WR:      stateNext = lastMsg ? DONE : RD;
      default: stateNext = IDLE;
    endcase
  end

  // Memory interface decodes straight from state and counters so a write lands in its own cycle.
  always_comb begin
    MemAddr   = '0;
    MemWrEn   = 1'b0;
    MemWrData = '0;
    case (stateReg)
      PRE: begin
        MemAddr   = dstBaseReg + jReg;
        MemWrEn   = 1'b1;
        MemWrData = PAD ^ padWord;
      end
      RD: MemAddr = srcBaseReg + iReg;
      WR: begin
        MemAddr   = dstBaseReg + preLenReg + iReg;
        MemWrEn   = 1'b1;
        MemWrData = rbufReg ^ padWord;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lfsrReg    <= '0;
      tapReg     <= '0;
      srcBaseReg <= '0;
      dstBaseReg <= '0;
      lenReg     <= '0;
      preLenReg  <= '0;
      iReg       <= '0;
      jReg       <= '0;
      rbufReg    <= '0;
      busyReg    <= 1'b0;
      ackReg     <= 1'b0;
    end else begin
      busyReg <= (stateNext == PRE) || (stateNext == RD) || (stateNext == WR);
      ackReg  <= (stateNext == DONE);
      if (startOk) begin
        tapReg     <= Tap;
        lfsrReg    <= Seed;
        srcBaseReg <= SrcBase;
        dstBaseReg <= DstBase;
        lenReg     <= Len;
        preLenReg  <= PreLen;
        iReg       <= '0;
        jReg       <= '0;
      end else begin
        case (stateReg)
          PRE: begin
            lfsrReg <= lfsrStep;
            jReg    <= jReg + ONE_A;
          end
          RD: rbufReg <= MemRdData;
          WR: begin
            lfsrReg <= lfsrStep;
            iReg    <= iReg + ONE_A;
          end
          default: ;
        endcase
      end
    end
  end

  assign Busy = busyReg;
  assign Ack  = ackReg;

endmodule

// File: tb/tb_lfsr_cipher_engine.sv
// Bench for lfsr_cipher_engine: table-driven jobs, hand-written corner sequences and random jobs,
// all checked against a char-by-char reference model of the cipher over a shadow memory.
module tb_lfsr_cipher_engine;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic [6:0] Tap, Seed;
  logic [7:0] SrcBase, DstBase, Len, PreLen;
  logic [7:0] MemAddr;
  logic       MemWrEn;
  logic [7:0] MemWrData;
  logic [7:0] MemRdData;
  logic       Busy, Ack;

  logic [7:0] mem[256];
  logic [7:0] modelMem[256];
  logic [7:0] wrA[$], wrD[$], rdA[$];

  int vectors = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  assign MemRdData = mem[MemAddr];

  lfsr_cipher_engine dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Tap(Tap), .Seed(Seed),
    .SrcBase(SrcBase), .DstBase(DstBase), .Len(Len), .PreLen(PreLen),
    .MemAddr(MemAddr), .MemWrEn(MemWrEn), .MemWrData(MemWrData), .MemRdData(MemRdData),
    .Busy(Busy), .Ack(Ack)
  );

  typedef struct {
    logic [6:0] tap;
    logic [6:0] seed;
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] len;
    logic [7:0] pre;
    int         glitch;
    int         expBusy;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Shift left, feed back the parity of the tapped bits.
  function automatic logic [6:0] nextState(input logic [6:0] s, input logic [6:0] t);
    int v;
    v = (int'(s) * 2) % 128 + ($countones(s & t) % 2);
    return 7'(v);
  endfunction

  task automatic do_job(input logic [6:0] tap, input logic [6:0] seed,
                        input logic [7:0] src, input logic [7:0] dst,
                        input logic [7:0] len, input logic [7:0] pre,
                        input int glitch, output int busy);
    logic [7:0] expA[$], expD[$], expR[$];
    logic [6:0] s;
    logic [7:0] a, d;
    int n, diffs;
    bit done;

    modelMem = mem;
    s = seed;
    for (int j = 0; j < int'(pre); j++) begin
      expA.push_back(8'(int'(dst) + j));
      expD.push_back(8'h20 ^ {1'b0, s});
      modelMem[8'(int'(dst) + j)] = 8'h20 ^ {1'b0, s};
      s = nextState(s, tap);
    end
    for (int i = 0; i < int'(len); i++) begin
      expR.push_back(8'(int'(src) + i));
      a = 8'(int'(dst) + int'(pre) + i);
      d = modelMem[8'(int'(src) + i)] ^ {1'b0, s};
      modelMem[a] = d;
      expA.push_back(a);
      expD.push_back(d);
      s = nextState(s, tap);
    end

    wrA.delete(); wrD.delete(); rdA.delete();
    @(negedge Clk);
    Tap = tap; Seed = seed; SrcBase = src; DstBase = dst; Len = len; PreLen = pre;
    Start = 1'b1;
    busy = 0;
    done = 0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge Clk);
      if (c == 0) begin
        Start = 1'b0;
        check("ack_after_start", 32'(Ack), 32'(pre == 0 && len == 0));
      end
      if (glitch >= 0 && c == glitch) begin
        Start = 1'b1;
        Tap = 7'($urandom); Seed = 7'($urandom);
        SrcBase = 8'($urandom); DstBase = 8'($urandom);
        Len = 8'($urandom); PreLen = 8'($urandom);
      end
      if (glitch >= 0 && c == glitch + 1) Start = 1'b0;
      if (MemWrEn) begin
        wrA.push_back(MemAddr);
        wrD.push_back(MemWrData);
        mem[MemAddr] = MemWrData;
      end
      if (Busy && !MemWrEn) rdA.push_back(MemAddr);
      if (Ack) done = 1;
      else if (Busy) busy++;
    end

    check("ack_end", 32'(Ack), 32'd1);
    check("busy_cycles", 32'(busy), 32'(int'(pre) + 2 * int'(len)));
    check("write_count", 32'(wrA.size()), 32'(expA.size()));
    n = (wrA.size() < expA.size()) ? wrA.size() : expA.size();
    for (int k = 0; k < n; k++)
      check($sformatf("write[%0d] addr/data", k), {16'h0, wrA[k], wrD[k]}, {16'h0, expA[k], expD[k]});
    check("read_count", 32'(rdA.size()), 32'(expR.size()));
    n = (rdA.size() < expR.size()) ? rdA.size() : expR.size();
    for (int k = 0; k < n; k++)
      check($sformatf("read[%0d] addr", k), 32'(rdA[k]), 32'(expR[k]));
    diffs = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== modelMem[k]) diffs++;
    check("memory_image", 32'(diffs), 32'd0);
    $display("job tap=%h seed=%h src=%h dst=%h len=%0d pre=%0d busy=%0d writes=%0d",
             tap, seed, src, dst, len, pre, busy, wrA.size());
  endtask

  logic [7:0] padC[8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h41, 8'h03};
  logic [7:0] wrapC[4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
  logic [7:0] exC[3]   = '{8'h21, 8'h22, 8'h45};
  logic [7:0] pt[8];

  initial begin
    int busy;
    bit hit;

    vecs[0] = '{7'h60, 7'h01, 8'h10, 8'h40, 8'd1,  8'd2, -1, 4};
    vecs[1] = '{7'h60, 7'h01, 8'h20, 8'h60, 8'd8,  8'd0, -1, 16};
    vecs[2] = '{7'h00, 7'h55, 8'h30, 8'h80, 8'd3,  8'd0, -1, 6};
    vecs[3] = '{7'h7F, 7'h00, 8'h30, 8'h90, 8'd2,  8'd1, -1, 5};
    vecs[4] = '{7'h60, 7'h01, 8'h00, 8'h00, 8'd0,  8'd0, -1, 0};
    vecs[5] = '{7'h60, 7'h01, 8'h00, 8'hA0, 8'd0,  8'd3, -1, 3};
    vecs[6] = '{7'h60, 7'h05, 8'hFE, 8'hB0, 8'd4,  8'd0, -1, 8};
    vecs[7] = '{7'h33, 7'h11, 8'h50, 8'h58, 8'd10, 8'd2, 5, 22};
    vecs[8] = '{7'h60, 7'h01, 8'hF0, 8'hF8, 8'd6,  8'd4, 3, 16};

    for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
    Reset = 1'b1; Start = 1'b0;
    Tap = '0; Seed = '0; SrcBase = '0; DstBase = '0; Len = '0; PreLen = '0;
    repeat (2) @(negedge Clk);
    check("reset_outputs", {8'h0, 5'h0, MemWrEn, Busy, Ack, MemAddr, MemWrData}, 32'h0);
    Reset = 1'b0;

    foreach (vecs[v]) begin
      do_job(vecs[v].tap, vecs[v].seed, vecs[v].src, vecs[v].dst,
             vecs[v].len, vecs[v].pre, vecs[v].glitch, busy);
      check($sformatf("table[%0d] busy", v), 32'(busy), 32'(vecs[v].expBusy));
    end

    // Worked example with hand-computed ciphertext.
    mem[8'h10] = 8'h41;
    do_job(7'h60, 7'h01, 8'h10, 8'h40, 8'd1, 8'd2, -1, busy);
    check("example_writes", 32'(wrD.size()), 32'd3);
    if (wrD.size() == 3)
      for (int k = 0; k < 3; k++)
        check($sformatf("example[%0d]", k), {16'h0, wrA[k], wrD[k]}, {16'h0, 8'(8'h40 + k), exC[k]});

    // Pad sequence, then decrypting the output restores the plaintext.
    for (int k = 0; k < 8; k++) begin
      pt[k] = 8'($urandom);
      mem[8'h20 + k] = pt[k];
    end
    do_job(7'h60, 7'h01, 8'h20, 8'h60, 8'd8, 8'd0, -1, busy);
    if (wrD.size() == 8)
      for (int k = 0; k < 8; k++)
        check($sformatf("pad[%0d]", k), 32'(wrD[k] ^ pt[k]), 32'(padC[k]));
    else
      check("pad_write_count", 32'(wrD.size()), 32'd8);
    do_job(7'h60, 7'h01, 8'h60, 8'h70, 8'd8, 8'd0, -1, busy);
    for (int k = 0; k < 8; k++)
      check($sformatf("roundtrip[%0d]", k), 32'(mem[8'h70 + k]), 32'(pt[k]));

    // Source address wraps past the top of memory.
    do_job(7'h60, 7'h05, 8'hFE, 8'hC0, 8'd4, 8'd0, -1, busy);
    if (rdA.size() == 4)
      for (int k = 0; k < 4; k++)
        check($sformatf("wrap_read[%0d]", k), 32'(rdA[k]), 32'(wrapC[k]));
    else
      check("wrap_read_count", 32'(rdA.size()), 32'd4);

    // Reset while a message write is in progress.
    @(negedge Clk);
    Tap = 7'h60; Seed = 7'h01; SrcBase = 8'h10; DstBase = 8'hD0; Len = 8'd5; PreLen = 8'd0;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      if (MemWrEn) hit = 1;
      else @(negedge Clk);
    end
    check("reached_wr", 32'(hit), 32'd1);
    #2 Reset = 1'b1;
    @(negedge Clk);
    check("reset_mid_wr", {8'h0, 5'h0, MemWrEn, Busy, Ack, MemAddr, MemWrData}, 32'h0);
    Reset = 1'b0;
    $display("job reset asserted during a message write");
    do_job(7'h41, 7'h2A, 8'h30, 8'hD0, 8'd5, 8'd1, -1, busy);

    for (int r = 0; r < 20; r++) begin
      logic [7:0] l, p;
      l = 8'($urandom_range(0, 12));
      p = 8'($urandom_range(0, 5));
      do_job(7'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), l, p,
             ((int'(p) + 2 * int'(l)) > 3 && ($urandom % 2 == 0)) ? 1 : -1, busy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
